// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/load register: accepts an operand and opcode, then shifts one
// bit per clock (logical, arithmetic or rotate) with a start/busy/done handshake.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   d,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sin,
  output logic [WIDTH-1:0]   q,
  output logic               cout,
  output logic [SHAMT_W-1:0] cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LSL   = 3'b001;
  localparam logic [2:0] OP_LSR   = 3'b010;
  localparam logic [2:0] OP_ASR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [2:0]        op_l;
  logic              accept;
  logic              is_shift;
  logic [WIDTH-1:0]  shift_q;
  logic              shift_out;

  assign is_shift = (op >= OP_LSL) && (op <= OP_ROR);

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // A new request is taken whenever no shift is in flight, including the DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (is_shift && (shamt != CNT_ZERO)) state_nxt = SHIFT;
          else                                 state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == CNT_ONE) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == SHIFT);
    done   = (state == DONE);
    accept = start && (state != SHIFT);
  end

  // One-bit step of the latched operation; the outgoing bit becomes cout.
  always_comb begin
    shift_q   = q;
    shift_out = 1'b0;
    case (op_l)
      OP_LSL: begin shift_q = {q[WIDTH-2:0], sin};      shift_out = q[WIDTH-1]; end
      OP_LSR: begin shift_q = {sin, q[WIDTH-1:1]};      shift_out = q[0];       end
      OP_ASR: begin shift_q = {q[WIDTH-1], q[WIDTH-1:1]}; shift_out = q[0];     end
      OP_ROL: begin shift_q = {q[WIDTH-2:0], q[WIDTH-1]}; shift_out = q[WIDTH-1]; end
      OP_ROR: begin shift_q = {q[0], q[WIDTH-1:1]};     shift_out = q[0];       end
      default: begin shift_q = q; shift_out = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q    <= '0;
      cout <= 1'b0;
      cnt  <= '0;
      op_l <= OP_NOP;
    end else if (accept) begin
      cout <= 1'b0;
      op_l <= op;
      case (op)
        OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: begin
          q   <= d;
          cnt <= shamt;
        end
        OP_LOAD: begin
          q   <= d;
          cnt <= '0;
        end
        OP_CLEAR: begin
          q   <= '0;
          cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end else if (state == SHIFT) begin
      q    <= shift_q;
      cout <= shift_out;
      cnt  <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed, table-driven bench for seq_shift_unit at WIDTH=32, SHAMT_W=6, plus
// hand-written sequences for reset mid-shift, start while busy and back-to-back accepts.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  op;
  logic [31:0] d;
  logic [5:0]  shamt;
  logic        sin;
  logic [31:0] q;
  logic        cout;
  logic [5:0]  cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(6)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .d(d), .shamt(shamt),
    .sin(sin), .q(q), .cout(cout), .cnt(cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] d;
    logic [5:0]  shamt;
    logic        sin;
    logic [31:0] exp_q;
    logic        exp_cout;
    int          n;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, follow it to its done pulse, then check result and timing.
  task automatic applyStimulus(input vec_t v);
    int   cyc;
    logic cnt_ok;
    logic saw_done;
    @(negedge clk);
    start = 1'b1; op = v.op; d = v.d; shamt = v.shamt; sin = v.sin;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; cnt_ok = 1'b1; saw_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (busy) begin
        if (cnt !== 6'(v.n - cyc)) cnt_ok = 1'b0;
        cyc++;
      end
      @(negedge clk);
    end
    checkOutput({v.name, " done seen"}, {31'b0, saw_done}, 32'd1);
    checkOutput({v.name, " busy cycles"}, cyc, v.n);
    checkOutput({v.name, " cnt countdown"}, {31'b0, cnt_ok}, 32'd1);
    checkOutput({v.name, " q"}, q, v.exp_q);
    checkOutput({v.name, " cout"}, {31'b0, cout}, {31'b0, v.exp_cout});
    checkOutput({v.name, " cnt at done"}, {26'b0, cnt}, 32'd0);
    @(negedge clk);
    checkOutput({v.name, " done one cycle"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"LSL 1 by 4",        3'b001, 32'h00000001, 6'd4,  1'b0, 32'h00000010, 1'b0, 4};
    vecs[1]  = '{"ASR sign by 31",    3'b011, 32'h80000000, 6'd31, 1'b0, 32'hFFFFFFFF, 1'b0, 31};
    vecs[2]  = '{"ROR 1 by 1",        3'b101, 32'h00000001, 6'd1,  1'b0, 32'h80000000, 1'b1, 1};
    vecs[3]  = '{"LSR fill by 40",    3'b010, 32'h0000000F, 6'd40, 1'b1, 32'hFFFFFFFF, 1'b1, 40};
    vecs[4]  = '{"ROL wrap by 33",    3'b100, 32'h80000001, 6'd33, 1'b0, 32'h00000003, 1'b1, 33};
    vecs[5]  = '{"LSL shamt 0",       3'b001, 32'hF0000000, 6'd0,  1'b0, 32'hF0000000, 1'b0, 0};
    vecs[6]  = '{"LSR by 35",         3'b010, 32'h80000000, 6'd35, 1'b0, 32'h00000000, 1'b0, 35};
    vecs[7]  = '{"LOAD",              3'b110, 32'hDEADBEEF, 6'd9,  1'b0, 32'hDEADBEEF, 1'b0, 0};
    vecs[8]  = '{"NOP holds",         3'b000, 32'h11111111, 6'd5,  1'b0, 32'hDEADBEEF, 1'b0, 0};
    vecs[9]  = '{"CLEAR",             3'b111, 32'h22222222, 6'd5,  1'b0, 32'h00000000, 1'b0, 0};
    vecs[10] = '{"ASR pos by 2",      3'b011, 32'h40000000, 6'd2,  1'b0, 32'h10000000, 1'b0, 2};
    vecs[11] = '{"LSL sin by 1",      3'b001, 32'h80000000, 6'd1,  1'b1, 32'h00000001, 1'b1, 1};
    vecs[12] = '{"NOP clears cout",   3'b000, 32'hFFFFFFFF, 6'd3,  1'b0, 32'h00000001, 1'b0, 0};

    clr = 1'b1; start = 1'b0; op = 3'b000; d = '0; shamt = '0; sin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset q", q, 32'h0);
    checkOutput("reset busy/done/cout", {29'b0, busy, done, cout}, 32'd0);
    clr = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset mid-shift takes effect at the first clr edge.
    @(negedge clk);
    start = 1'b1; op = 3'b001; d = 32'h000000FF; shamt = 6'd10; sin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre-reset busy", {31'b0, busy}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    checkOutput("midshift reset q", q, 32'h0);
    checkOutput("midshift reset cnt", {26'b0, cnt}, 32'd0);
    checkOutput("midshift reset flags", {29'b0, busy, done, cout}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("post-reset idle", {30'b0, busy, done}, 32'd0);

    // Start held during a busy LSL is ignored, then accepted in the DONE cycle.
    start = 1'b1; op = 3'b001; d = 32'h000000AB; shamt = 6'd8; sin = 1'b0;
    @(negedge clk);
    op = 3'b110; d = 32'h12345678; shamt = 6'd2;
    begin
      int waited = 0;
      while (!done && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("busy-start busy cycles", waited, 32'd8);
    end
    checkOutput("busy-start q", q, 32'h0000AB00);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy-start LOAD done", {31'b0, done}, 32'd1);
    checkOutput("busy-start LOAD q", q, 32'h12345678);
    @(negedge clk);

    // LOAD then CLEAR accepted in LOAD's DONE cycle.
    start = 1'b1; op = 3'b110; d = 32'hDEADBEEF;
    @(negedge clk);
    op = 3'b111;
    checkOutput("b2b LOAD done", {31'b0, done}, 32'd1);
    checkOutput("b2b LOAD q", q, 32'hDEADBEEF);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b CLEAR done", {31'b0, done}, 32'd1);
    checkOutput("b2b CLEAR q", q, 32'h0);
    @(negedge clk);
    checkOutput("b2b idle", {30'b0, busy, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
